// File: rtl/acorn128_pkg.sv
// Shared constants, phase encoding and boolean helpers for the bit-serial
// ACORN-128 (v3) datapath, used by both the encrypt and decrypt tops.
package acorn128_pkg;

  localparam int STATE_W = 293;
  localparam int BLOCK_W = 128;
  localparam int CNT_W   = 12;

  typedef logic [2:0] phase_t;

  localparam phase_t PH_IDLE  = 3'd0;
  localparam phase_t PH_INIT  = 3'd1;
  localparam phase_t PH_AD    = 3'd2;
  localparam phase_t PH_MSG   = 3'd3;
  localparam phase_t PH_FINAL = 3'd4;
  localparam phase_t PH_DONE  = 3'd5;

  localparam logic [CNT_W-1:0] INIT_STEPS  = 12'd1792;
  localparam logic [CNT_W-1:0] PAD_STEPS   = 12'd256;
  localparam logic [CNT_W-1:0] FINAL_STEPS = 12'd768;
  localparam logic [CNT_W-1:0] BLOCK_STEPS = 12'd128;
  localparam logic [CNT_W-1:0] DATA_STEPS  = BLOCK_STEPS + PAD_STEPS;
  localparam logic [CNT_W-1:0] INIT_LAST   = INIT_STEPS - 12'd1;
  localparam logic [CNT_W-1:0] DATA_LAST   = DATA_STEPS - 12'd1;
  localparam logic [CNT_W-1:0] CA_STEPS    = 12'd256;
  localparam logic [CNT_W-1:0] KEY_FLIP    = 12'd256;
  localparam logic [CNT_W-1:0] TAG_FIRST   = FINAL_STEPS - BLOCK_STEPS;

  // Keystream taps
  localparam int KS_T0  = 12;
  localparam int KS_T1  = 154;
  localparam int KS_MJ0 = 235;
  localparam int KS_MJ1 = 61;
  localparam int KS_MJ2 = 193;
  localparam int KS_CH0 = 230;
  localparam int KS_CH1 = 111;
  localparam int KS_CH2 = 66;

  // Feedback taps
  localparam int F_T0  = 0;
  localparam int F_T1  = 107;
  localparam int F_MJ0 = 244;
  localparam int F_MJ1 = 23;
  localparam int F_MJ2 = 160;
  localparam int F_CA  = 196;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

endpackage

// File: rtl/acorn128_step.sv
// One combinational ACORN-128 v3 state-update step. The keystream bit does not
// depend on m, so callers may derive m from ks (decryption) without a loop.
module acorn128_step
  import acorn128_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic               m,
  input  logic               ca,
  input  logic               cb,
  output logic [STATE_W-1:0] state_next,
  output logic               ks
);

  logic [STATE_W-1:0] s;
  logic               f;

  // NOTE: s takes a full default before the partial overrides, so no bit can
  // hold its previous value and infer a latch.
  always_comb begin
    s = state;
    // The six LFSR boundaries all read pre-update values.
    s[289] = state[289] ^ state[235] ^ state[230];
    s[230] = state[230] ^ state[196] ^ state[193];
    s[193] = state[193] ^ state[160] ^ state[154];
    s[154] = state[154] ^ state[111] ^ state[107];
    s[107] = state[107] ^ state[66]  ^ state[61];
    s[61]  = state[61]  ^ state[23]  ^ state[0];
  end

  assign ks = s[KS_T0] ^ s[KS_T1]
            ^ maj(s[KS_MJ0], s[KS_MJ1], s[KS_MJ2])
            ^ ch(s[KS_CH0], s[KS_CH1], s[KS_CH2]);

  assign f = s[F_T0] ^ ~s[F_T1]
           ^ maj(s[F_MJ0], s[F_MJ1], s[F_MJ2])
           ^ (ca & s[F_CA]) ^ (cb & ks);

  assign state_next = {f ^ m, s[STATE_W-1:1]};

endmodule

// File: rtl/acorn128_decrypt.sv
// Bit-serial ACORN-128 decrypt/verify: one update step per clock; plaintext is
// released only when the recomputed tag equals tag_in.
module acorn128_decrypt
  import acorn128_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_in,
  input  logic [BLOCK_W-1:0] key_in,
  input  logic [BLOCK_W-1:0] iv_in,
  input  logic [BLOCK_W-1:0] associated_data_in,
  input  logic [BLOCK_W-1:0] ciphertext_in,
  input  logic [BLOCK_W-1:0] tag_in,
  output logic [BLOCK_W-1:0] plaintext_out,
  output logic [BLOCK_W-1:0] tag_out,
  output logic               auth_ok_out,
  output logic               busy_out,
  output logic               done_out,
  output logic               ready_out
);

  phase_t             phase;
  logic [CNT_W-1:0]   cnt;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic [BLOCK_W-1:0] key_q;
  logic [BLOCK_W-1:0] iv_q;
  logic [BLOCK_W-1:0] ad_q;
  logic [BLOCK_W-1:0] ct_q;
  logic [BLOCK_W-1:0] tag_q;
  logic [BLOCK_W-1:0] pt_shadow;
  logic [6:0]         bit_idx;
  logic               ks;
  logic               m;
  logic               ca;
  logic               cb;
  logic               step_en;
  logic               phase_last;
  logic               tag_match;

  assign bit_idx   = cnt[6:0];
  assign tag_match = (tag_out == tag_q);

  acorn128_step u_step (
    .state      (state),
    .m          (m),
    .ca         (ca),
    .cb         (cb),
    .state_next (state_next),
    .ks         (ks)
  );

  always_comb begin
    m          = 1'b0;
    ca         = 1'b1;
    cb         = 1'b1;
    step_en    = 1'b0;
    phase_last = 1'b0;
    case (phase)
      PH_INIT: begin
        step_en    = 1'b1;
        // The key repeats every 128 steps, so the low counter bits index it directly.
        m          = (cnt[11:7] == 5'd1) ? iv_q[bit_idx]
                                         : key_q[bit_idx] ^ (cnt == KEY_FLIP);
        phase_last = (cnt == INIT_LAST);
      end
      PH_AD: begin
        step_en    = 1'b1;
        m          = (cnt < BLOCK_STEPS) ? ad_q[bit_idx] : (cnt == BLOCK_STEPS);
        ca         = (cnt < CA_STEPS);
        phase_last = (cnt == DATA_LAST);
      end
      PH_MSG: begin
        step_en    = 1'b1;
        cb         = 1'b0;
        m          = (cnt < BLOCK_STEPS) ? (ct_q[bit_idx] ^ ks) : (cnt == BLOCK_STEPS);
        ca         = (cnt < CA_STEPS);
        phase_last = (cnt == DATA_LAST);
      end
      PH_FINAL: begin
        // The extra count past the last step is the verify cycle.
        step_en = (cnt != FINAL_STEPS);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase         <= PH_IDLE;
      cnt           <= '0;
      state         <= '0;
      key_q         <= '0;
      iv_q          <= '0;
      ad_q          <= '0;
      ct_q          <= '0;
      tag_q         <= '0;
      pt_shadow     <= '0;
      plaintext_out <= '0;
      tag_out       <= '0;
      auth_ok_out   <= 1'b0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      ready_out     <= 1'b0;
    end else begin
      done_out <= 1'b0;
      if (step_en) begin
        state <= state_next;
        cnt   <= phase_last ? '0 : cnt + CNT_W'(1);
      end
      case (phase)
        PH_IDLE, PH_DONE: begin
          if (start_in) begin
            key_q         <= key_in;
            iv_q          <= iv_in;
            ad_q          <= associated_data_in;
            ct_q          <= ciphertext_in;
            tag_q         <= tag_in;
            state         <= '0;
            cnt           <= '0;
            pt_shadow     <= '0;
            plaintext_out <= '0;
            auth_ok_out   <= 1'b0;
            ready_out     <= 1'b0;
            busy_out      <= 1'b1;
            phase         <= PH_INIT;
          end
        end
        PH_INIT: if (phase_last) phase <= PH_AD;
        PH_AD:   if (phase_last) phase <= PH_MSG;
        PH_MSG: begin
          if (cnt < BLOCK_STEPS) pt_shadow <= {m, pt_shadow[BLOCK_W-1:1]};
          if (phase_last) phase <= PH_FINAL;
        end
        PH_FINAL: begin
          if (!step_en) begin
            phase         <= PH_DONE;
            done_out      <= 1'b1;
            ready_out     <= 1'b1;
            busy_out      <= 1'b0;
            auth_ok_out   <= tag_match;
            plaintext_out <= tag_match ? pt_shadow : '0;
          end else if (cnt >= TAG_FIRST) begin
            tag_out <= {ks, tag_out[BLOCK_W-1:1]};
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acorn128_decrypt.sv
// Self-checking bench for acorn128_decrypt against a bit-array reference of the
// ACORN-128 v3 cipher that also produces the ciphertext/tag vectors.
`timescale 1ns/1ps
module tb_acorn128_decrypt;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_in;
  logic [127:0] key_in;
  logic [127:0] iv_in;
  logic [127:0] associated_data_in;
  logic [127:0] ciphertext_in;
  logic [127:0] tag_in;
  logic [127:0] plaintext_out;
  logic [127:0] tag_out;
  logic         auth_ok_out;
  logic         busy_out;
  logic         done_out;
  logic         ready_out;

  always #5 clk = ~clk;

  acorn128_decrypt dut (
    .clk                (clk),
    .rst                (rst),
    .start_in           (start_in),
    .key_in             (key_in),
    .iv_in              (iv_in),
    .associated_data_in (associated_data_in),
    .ciphertext_in      (ciphertext_in),
    .tag_in             (tag_in),
    .plaintext_out      (plaintext_out),
    .tag_out            (tag_out),
    .auth_ok_out        (auth_ok_out),
    .busy_out           (busy_out),
    .done_out           (done_out),
    .ready_out          (ready_out)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    check(name, {127'b0, act}, {127'b0, req});
  endtask

  // Reference cipher: bit array updated in place, in the order of the reference C code.
  bit ms [0:292];

  function automatic bit f_maj(bit x, bit y, bit z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic bit f_ch(bit x, bit y, bit z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic int model_pop();
    int pc = 0;
    for (int j = 0; j < 293; j++) pc += int'(ms[j]);
    return pc;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < 293; j++) ms[j] = 1'b0;
  endtask

  task automatic m_update(input bit in_bit, input bit ca, input bit cb, input bit dec,
                          output bit ks, output bit out_bit);
    bit f;
    bit p;
    ms[289] ^= ms[235] ^ ms[230];
    ms[230] ^= ms[196] ^ ms[193];
    ms[193] ^= ms[160] ^ ms[154];
    ms[154] ^= ms[111] ^ ms[107];
    ms[107] ^= ms[66]  ^ ms[61];
    ms[61]  ^= ms[23]  ^ ms[0];
    ks = ms[12] ^ ms[154] ^ f_maj(ms[235], ms[61], ms[193]) ^ f_ch(ms[230], ms[111], ms[66]);
    f  = ms[0] ^ ~ms[107] ^ f_maj(ms[244], ms[23], ms[160]) ^ (ca & ms[196]) ^ (cb & ks);
    p  = dec ? (in_bit ^ ks) : in_bit;
    for (int j = 0; j < 292; j++) ms[j] = ms[j+1];
    ms[292] = f ^ p;
    out_bit = in_bit ^ ks;
  endtask

  // dec=0: data is plaintext, out_blk is ciphertext. dec=1: the reverse.
  task automatic model_run(input logic [127:0] key, input logic [127:0] iv,
                           input logic [127:0] ad, input logic [127:0] data, input bit dec,
                           output logic [127:0] out_blk, output logic [127:0] tag);
    bit ks;
    bit o;
    bit mb;
    model_clear();
    for (int i = 0; i < 1792; i++) begin
      if (i < 128)      mb = key[i];
      else if (i < 256) mb = iv[i-128];
      else              mb = key[(i-256) % 128] ^ (i == 256);
      m_update(mb, 1'b1, 1'b1, 1'b0, ks, o);
    end
    for (int i = 0; i < 384; i++) begin
      mb = (i < 128) ? ad[i] : (i == 128);
      m_update(mb, i < 256, 1'b1, 1'b0, ks, o);
    end
    for (int i = 0; i < 384; i++) begin
      if (i < 128) begin
        m_update(data[i], 1'b1, 1'b0, dec, ks, o);
        out_blk[i] = o;
      end else begin
        m_update(i == 128, i < 256, 1'b0, 1'b0, ks, o);
      end
    end
    for (int i = 0; i < 768; i++) begin
      m_update(1'b0, 1'b1, 1'b1, 1'b0, ks, o);
      if (i >= 640) tag[i-640] = ks;
    end
  endtask

  // Expectations for the compare process
  logic         exp_valid = 1'b0;
  logic [127:0] exp_pt    = '0;
  logic [127:0] exp_tag   = '0;
  logic         exp_auth  = 1'b0;
  int           done_seen = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (done_out) done_seen++;
      if (ready_out && exp_valid) begin
        check("result plaintext", plaintext_out, exp_pt);
        check("result tag", tag_out, exp_tag);
        check1("result auth", auth_ok_out, exp_auth);
        check1("result busy", busy_out, 1'b0);
      end else if (!ready_out) begin
        check("hidden plaintext", plaintext_out, 128'h0);
      end
    end
  end

  task automatic run_op(input string name, input logic [127:0] k, input logic [127:0] v,
                        input logic [127:0] a, input logic [127:0] c, input logic [127:0] t,
                        input logic [127:0] e_pt, input logic [127:0] e_tag, input bit e_auth);
    int n;
    int d0;
    @(posedge clk); #1;
    exp_valid          = 1'b0;
    key_in             = k;
    iv_in              = v;
    associated_data_in = a;
    ciphertext_in      = c;
    tag_in             = t;
    exp_pt             = e_pt;
    exp_tag            = e_tag;
    exp_auth           = e_auth;
    start_in           = 1'b1;
    @(posedge clk); #1;
    start_in  = 1'b0;
    exp_valid = 1'b1;
    check1({name, " busy after start"}, busy_out, 1'b1);
    check1({name, " ready after start"}, ready_out, 1'b0);
    d0 = done_seen;
    n  = 0;
    while (!done_out && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " latency"}, 128'(n), 128'd3329);
    repeat (3) @(posedge clk);
    #1;
    check({name, " done pulses"}, 128'(done_seen - d0), 128'd1);
    check1({name, " ready held"}, ready_out, 1'b1);
  endtask

  localparam logic [127:0] KEY_RT = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] IV_RT  = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] AD_RT  = 128'hDEADBEEF;
  localparam logic [127:0] PT_RT  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  initial begin
    logic [127:0] ct0, tag0, ct1, tag1, pt_chk, tag_chk, ct_f, pt_f, tag_f;
    bit           ks, o;
    int           n, d0;

    rst = 1'b1; start_in = 1'b0;
    key_in = '0; iv_in = '0; associated_data_in = '0; ciphertext_in = '0; tag_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset plaintext", plaintext_out, 128'h0);
    check("reset tag", tag_out, 128'h0);
    check1("reset auth", auth_ok_out, 1'b0);
    check1("reset busy", busy_out, 1'b0);
    check1("reset done", done_out, 1'b0);
    check1("reset ready", ready_out, 1'b0);
    rst = 1'b0;

    // Hand-derived single steps from the all-zero state pin the reference model.
    model_clear();
    m_update(1'b0, 1'b1, 1'b1, 1'b0, ks, o);
    check1("pin step1 ks", ks, 1'b0);
    check1("pin step1 s292", ms[292], 1'b1);
    check("pin step1 pop", 128'(model_pop()), 128'd1);
    m_update(1'b0, 1'b1, 1'b1, 1'b0, ks, o);
    check1("pin step2 s291", ms[291], 1'b1);
    check("pin step2 pop", 128'(model_pop()), 128'd2);
    model_clear();
    m_update(1'b1, 1'b1, 1'b1, 1'b0, ks, o);
    check("pin m1 pop", 128'(model_pop()), 128'd0);

    // All-zero key/iv/ad, plaintext zero
    model_run('0, '0, '0, '0, 1'b0, ct0, tag0);
    run_op("zero", '0, '0, '0, ct0, tag0, 128'h0, tag0, 1'b1);

    // Round trip
    model_run(KEY_RT, IV_RT, AD_RT, PT_RT, 1'b0, ct1, tag1);
    model_run(KEY_RT, IV_RT, AD_RT, ct1, 1'b1, pt_chk, tag_chk);
    check("model decrypt pt", pt_chk, PT_RT);
    check("model decrypt tag", tag_chk, tag1);
    run_op("roundtrip", KEY_RT, IV_RT, AD_RT, ct1, tag1, PT_RT, tag1, 1'b1);

    // Corrupted tag: recomputed tag unchanged, plaintext suppressed
    run_op("tagflip", KEY_RT, IV_RT, AD_RT, ct1, tag1 ^ 128'h1, 128'h0, tag1, 1'b0);

    // Corrupted ciphertext bit 77
    ct_f = ct1 ^ (128'h1 << 77);
    model_run(KEY_RT, IV_RT, AD_RT, ct_f, 1'b1, pt_f, tag_f);
    run_op("ctflip", KEY_RT, IV_RT, AD_RT, ct_f, tag1, 128'h0, tag_f, 1'b0);

    // start_in held high; key_in disturbed mid-run and restored before the re-start
    @(posedge clk); #1;
    exp_valid = 1'b0;
    key_in = KEY_RT; iv_in = IV_RT; associated_data_in = AD_RT;
    ciphertext_in = ct1; tag_in = tag1;
    exp_pt = PT_RT; exp_tag = tag1; exp_auth = 1'b1;
    start_in = 1'b1;
    @(posedge clk); #1;
    exp_valid = 1'b1;
    d0 = done_seen;
    n  = 0;
    while (!done_out && n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (n == 1500) key_in = ~KEY_RT;
      if (n == 3000) key_in = KEY_RT;
    end
    check("hold first latency", 128'(n), 128'd3329);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done_out && n < 4000);
    check("hold restart spacing", 128'(n), 128'd3330);
    start_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold done pulses", 128'(done_seen - d0), 128'd2);
    check1("hold ready", ready_out, 1'b1);

    // Reset in the middle of INIT
    @(posedge clk); #1;
    exp_valid = 1'b0;
    key_in = KEY_RT; start_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    repeat (1001) @(posedge clk);
    #1;
    check1("midrun busy", busy_out, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst plaintext", plaintext_out, 128'h0);
    check("midrst tag", tag_out, 128'h0);
    check1("midrst auth", auth_ok_out, 1'b0);
    check1("midrst busy", busy_out, 1'b0);
    check1("midrst done", done_out, 1'b0);
    check1("midrst ready", ready_out, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check1("idle stays idle", busy_out, 1'b0);

    run_op("after reset", '0, '0, '0, ct0, tag0, 128'h0, tag0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
